data_pack: RTL and testbench

Packs a framed stream of 7-bit values into LSB-first 32-bit words with sop/eop framing. It is the inverse of the 7-bit unpacker and sits directly upstream of it: its output port is handshake-compatible with the unpacker's 32-bit input port, so a pack/unpack pair forms a loopback. The final word of a packet is zero-padded in the upper unused bits. Output is registered and supports backpressure.

---
 rtl/data_pack_pkg.sv | 25 ++
 rtl/data_pack_datapath.sv | 111 +++++++++++
 rtl/data_pack.sv | 118 +++++++++++
 tb/tb_data_pack.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_pack_pkg.sv
// data_pack_pkg: shared definitions for the 7-bit to 32-bit packer.
//   state_t     packer FSM states (IDLE, PACK, FLUSH)
//   DEFAULT_*   default value / word widths
//   pad_mask()  mask with bits [n-1:0] set, used to zero-pad partial words
package data_pack_pkg;

  localparam int DEFAULT_IN_W  = 7;
  localparam int DEFAULT_OUT_W = 32;

  // pad_mask works on a fixed wide vector; callers slice to their width.
  localparam int MASK_W   = 64;
  localparam int MASK_N_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Bits below n are kept, bits at and above n are cleared.
  function automatic logic [MASK_W-1:0] pad_mask(input logic [MASK_N_W-1:0] n);
    return ~({MASK_W{1'b1}} << n);
  endfunction

endpackage

// File: rtl/data_pack_datapath.sv
// data_pack_datapath: bit accumulator for the packer.
// Holds acc (partial word plus overflow) and cnt (number of valid bits in acc).
//   data_in     value to insert at bit cnt
//   restart     treat acc/cnt as empty (first value of a packet)
//   pack_value  insert data_in this cycle
//   is_eop      the inserted value closes the packet
//   do_flush    emit the overflow remainder left by an eop
//   word_valid  a word is produced this cycle (word_data / word_last)
//   need_flush  the eop value overflowed; a FLUSH cycle must follow
module data_pack_datapath
  import data_pack_pkg::*;
#(
  parameter int IN_W  = DEFAULT_IN_W,
  parameter int OUT_W = DEFAULT_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  data_in,
  input  logic             restart,
  input  logic             pack_value,
  input  logic             is_eop,
  input  logic             do_flush,
  output logic             word_valid,
  output logic [OUT_W-1:0] word_data,
  output logic             word_last,
  output logic             need_flush
);

  localparam int ACC_W = OUT_W + IN_W - 1;
  localparam int CNT_W = $clog2(OUT_W);
  localparam int N_W   = $clog2(OUT_W + IN_W);

  localparam logic [N_W-1:0] OUT_W_N = N_W'(OUT_W);
  localparam logic [N_W-1:0] IN_W_N  = N_W'(IN_W);

  logic [ACC_W-1:0] acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic [CNT_W-1:0] base_cnt;
  logic [ACC_W-1:0] base_acc;
  logic [ACC_W-1:0] merged;
  logic [N_W-1:0]   n;
  logic [OUT_W-1:0] mask_n;
  logic [OUT_W-1:0] mask_cnt;

  // The first value of a packet always lands at bit 0 of an empty accumulator.
  assign base_cnt = restart ? '0 : cnt;
  assign base_acc = restart ? '0 : acc;

  assign merged   = (base_acc & ACC_W'(pad_mask(MASK_N_W'(base_cnt))))
                  | (ACC_W'(data_in) << base_cnt);
  assign n        = N_W'(base_cnt) + IN_W_N;
  assign mask_n   = OUT_W'(pad_mask(MASK_N_W'(n)));
  assign mask_cnt = OUT_W'(pad_mask(MASK_N_W'(cnt)));

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    word_valid = 1'b0;
    word_data  = '0;
    word_last  = 1'b0;
    need_flush = 1'b0;
    acc_d      = acc;
    cnt_d      = cnt;

    if (do_flush) begin
      word_valid = 1'b1;
      word_data  = acc[OUT_W-1:0] & mask_cnt;
      word_last  = 1'b1;
      acc_d      = '0;
      cnt_d      = '0;
    end else if (pack_value) begin
      if (is_eop && (n <= OUT_W_N)) begin
        // Packet fits in this word: zero the unused upper bits and close it.
        word_valid = 1'b1;
        word_data  = merged[OUT_W-1:0] & mask_n;
        word_last  = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
      end else if (is_eop) begin
        // Eop overflowed: send the full word now, remainder goes out in FLUSH.
        word_valid = 1'b1;
        word_data  = merged[OUT_W-1:0];
        need_flush = 1'b1;
        acc_d      = merged >> OUT_W;
        cnt_d      = CNT_W'(n - OUT_W_N);
      end else if (n >= OUT_W_N) begin
        word_valid = 1'b1;
        word_data  = merged[OUT_W-1:0];
        acc_d      = merged >> OUT_W;
        cnt_d      = CNT_W'(n - OUT_W_N);
      end else begin
        acc_d      = merged;
        cnt_d      = CNT_W'(n);
      end
    end
  end

  // NOTE: the accumulator is a plain register, not a memory, and a mid-packet
  // reset must discard it, so it is reset together with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_d;
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/data_pack.sv
// data_pack: packs a framed stream of IN_W-bit values into LSB-first
// OUT_W-bit words; the last word of a packet is zero-padded.
//   clk, rst                      clock, synchronous active-high reset
//   valid_in/ready_out            input handshake (transfer on both high)
//   data_in, sop_in, eop_in       input value and packet framing
//   valid_out/ready_in            output handshake (transfer on both high)
//   data_out, sop_out, eop_out    registered output word and framing
//   err_out                       one-cycle pulse: sop seen inside a packet
module data_pack
  import data_pack_pkg::*;
#(
  parameter int IN_W  = DEFAULT_IN_W,
  parameter int OUT_W = DEFAULT_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready_out,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  data_in,
  input  logic             sop_in,
  input  logic             eop_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [OUT_W-1:0] data_out,
  output logic             sop_out,
  output logic             eop_out,
  output logic             err_out
);

  state_t state, state_d;
  logic   first;

  logic             out_free;
  logic             accept;
  logic             restart;
  logic             pack_value;
  logic             do_flush;
  logic             sop_flag;
  logic             word_valid;
  logic [OUT_W-1:0] word_data;
  logic             word_last;
  logic             need_flush;

  // Output register can take a new word when empty or being drained now.
  assign out_free   = !valid_out || ready_in;
  assign ready_out  = (state != FLUSH) && out_free;
  assign accept     = valid_in && ready_out;
  assign restart    = (state == IDLE);
  // Out of packet only a sop value is packed; anything else is dropped.
  assign pack_value = accept && ((state == PACK) || ((state == IDLE) && sop_in));
  assign do_flush   = (state == FLUSH) && out_free;
  assign sop_flag   = restart || first;

  data_pack_datapath #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .restart    (restart),
    .pack_value (pack_value),
    .is_eop     (eop_in),
    .do_flush   (do_flush),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_last  (word_last),
    .need_flush (need_flush)
  );

  always_comb begin
    state_d = state;
    if (pack_value) begin
      if (need_flush)  state_d = FLUSH;
      else if (eop_in) state_d = IDLE;
      else             state_d = PACK;
    end else if (do_flush) begin
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      err_out   <= 1'b0;
      first     <= 1'b0;
    end else begin
      // A sop inside a packet is packed as data and flagged a cycle later.
      err_out <= accept && sop_in && (state == PACK);
      if (word_valid) begin
        valid_out <= 1'b1;
        data_out  <= word_data;
        sop_out   <= sop_flag;
        eop_out   <= word_last;
        first     <= 1'b0;
      end else begin
        if (pack_value && restart) first <= 1'b1;
        if (ready_in) begin
          valid_out <= 1'b0;
          data_out  <= '0;
          sop_out   <= 1'b0;
          eop_out   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_pack.sv
// tb_data_pack: self-checking bench for data_pack. A bit-queue reference
// model builds the expected word stream; a monitor collects transferred words.
module tb_data_pack;

  localparam int IN_W        = 7;
  localparam int OUT_W       = 32;
  localparam int STALL_LIMIT = 60;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready_out;
  logic             valid_in;
  logic [IN_W-1:0]  data_in;
  logic             sop_in;
  logic             eop_in;
  logic             ready_in;
  logic             valid_out;
  logic [OUT_W-1:0] data_out;
  logic             sop_out;
  logic             eop_out;
  logic             err_out;

  always #5 clk = ~clk;

  data_pack #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ready_out (ready_out),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .sop_in    (sop_in),
    .eop_in    (eop_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .err_out   (err_out)
  );

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sop;
    logic             eop;
  } word_t;

  word_t exp_q[$];
  word_t got_q[$];
  word_t aligned_ref[$];

  int total    = 0;
  int bad      = 0;
  int err_seen = 0;
  int err_exp  = 0;
  bit rand_bp  = 1'b0;

  // Reference model: packet bits kept as a plain FIFO of bits.
  bit m_in_pkt = 1'b0;
  bit m_first  = 1'b0;
  bit m_bits[$];

  // Monitor: record every output transfer and every err_out cycle.
  always @(negedge clk) begin
    #2;
    if (!rst && valid_out && ready_in) got_q.push_back({data_out, sop_out, eop_out});
    if (!rst && err_out) err_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input logic [63:0] observed, input logic [63:0] expected, input string tag);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic emit_chunk(input int nbits, input bit last);
    word_t w;
    w = '0;
    for (int i = 0; i < nbits; i++) w.data[i] = m_bits.pop_front();
    w.sop   = m_first;
    w.eop   = last;
    m_first = 1'b0;
    exp_q.push_back(w);
  endtask

  task automatic model_accept(input logic [IN_W-1:0] v, input logic s, input logic e);
    bit use_it;
    use_it = 1'b1;
    if (!m_in_pkt) begin
      if (s) begin
        m_in_pkt = 1'b1;
        m_first  = 1'b1;
        m_bits.delete();
      end else begin
        use_it = 1'b0;
      end
    end else if (s) begin
      err_exp++;
    end
    if (use_it) begin
      for (int i = 0; i < IN_W; i++) m_bits.push_back(v[i]);
      if (!e) begin
        if (m_bits.size() >= OUT_W) emit_chunk(OUT_W, 1'b0);
      end else begin
        while (m_bits.size() > OUT_W) emit_chunk(OUT_W, 1'b0);
        emit_chunk(m_bits.size(), 1'b1);
        m_in_pkt = 1'b0;
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input logic [IN_W-1:0] v, input logic s, input logic e, output int stalls);
    stalls = 0;
    if (rand_bp) ready_in = ($urandom_range(0, 3) != 0);
    valid_in = 1'b1;
    data_in  = v;
    sop_in   = s;
    eop_in   = e;
    #1;
    while (!ready_out && stalls < STALL_LIMIT) begin
      @(negedge clk);
      if (rand_bp) ready_in = ($urandom_range(0, 1) == 1);
      #1;
      stalls++;
    end
    check(ready_out, 1'b1, "accept_timeout");
    if (ready_out) begin
      @(posedge clk);
      model_accept(v, s, e);
    end
    @(negedge clk);
    valid_in = 1'b0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
  endtask

  task automatic drain(input string tag);
    ready_in = 1'b1;
    valid_in = 1'b0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    check(valid_out, 1'b0, {tag, "_drain_idle"});
    @(negedge clk);
  endtask

  task automatic compare_queues(input string tag);
    check(got_q.size(), exp_q.size(), {tag, "_word_count"});
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check(got_q[k], exp_q[k], {tag, "_word"});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int              stalls;
    int              stall_sum;
    int              err_base;
    int              len;
    int              gap;
    logic [IN_W-1:0] a, b, c;

    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
    ready_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check(valid_out, 1'b0, "reset_valid_out");
    check(data_out, 32'h0, "reset_data_out");
    check({sop_out, eop_out, err_out}, 3'b000, "reset_flags");
    check(ready_out, 1'b1, "reset_ready_out");
    @(negedge clk);

    // Full aligned packet: 32 values 0..31.
    stall_sum = 0;
    for (int i = 0; i < 32; i++) begin
      send(IN_W'(i), i == 0, i == 31, stalls);
      stall_sum += stalls;
    end
    check(stall_sum, 0, "aligned_no_bubbles");
    drain("aligned");
    check(got_q.size(), 7, "aligned_count");
    check(got_q[0].data, 32'h40608080, "aligned_word0");
    for (int k = 0; k < got_q.size(); k++)
      check({got_q[k].sop, got_q[k].eop}, {k == 0, k == 6}, "aligned_flags");
    aligned_ref = exp_q;
    compare_queues("aligned");

    // One-value packet.
    send(7'h7F, 1'b1, 1'b1, stalls);
    drain("single");
    check(got_q.size(), 1, "single_count");
    check(got_q[0], {32'h0000007F, 1'b1, 1'b1}, "single_word");
    compare_queues("single");

    // Overflow flush: 35 bits.
    for (int i = 0; i < 5; i++) send(7'h7F, i == 0, i == 4, stalls);
    #1;
    check(ready_out, 1'b0, "flush_ready_low");
    @(negedge clk);
    #1;
    check(ready_out, 1'b1, "flush_ready_back");
    drain("flush");
    check(got_q.size(), 2, "flush_count");
    check(got_q[0], {32'hFFFFFFFF, 1'b1, 1'b0}, "flush_word0");
    check(got_q[1], {32'h00000007, 1'b0, 1'b1}, "flush_word1");
    compare_queues("flush");

    // Values outside a packet are discarded.
    for (int i = 0; i < 3; i++) send(IN_W'($urandom), 1'b0, i == 1, stalls);
    send(7'h01, 1'b1, 1'b1, stalls);
    drain("discard");
    check(got_q.size(), 1, "discard_count");
    check(got_q[0], {32'h00000001, 1'b1, 1'b1}, "discard_word");
    compare_queues("discard");

    // Sop inside a packet: packed as data, err_out pulses once.
    err_base = err_seen;
    a = IN_W'($urandom);
    b = IN_W'($urandom);
    c = IN_W'($urandom);
    send(a, 1'b1, 1'b0, stalls);
    send(b, 1'b1, 1'b0, stalls);
    send(c, 1'b0, 1'b1, stalls);
    drain("err");
    check(err_seen - err_base, 1, "err_pulse_cycles");
    check(got_q[0].data, {11'b0, c, b, a}, "err_word_contents");
    check(err_seen, err_exp, "err_count_model");
    compare_queues("err");

    // Backpressure: hold a pending word for 3 cycles.
    for (int i = 0; i < 5; i++) send(IN_W'($urandom), i == 0, 1'b0, stalls);
    ready_in = 1'b0;
    #1;
    check(valid_out, 1'b1, "bp_valid");
    check(ready_out, 1'b0, "bp_ready_low");
    repeat (3) begin
      @(negedge clk);
      #1;
      check({valid_out, data_out, sop_out, eop_out}, {1'b1, exp_q[0]}, "bp_hold");
      check(ready_out, 1'b0, "bp_ready_low_hold");
    end
    ready_in = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) send(IN_W'($urandom), 1'b0, i == 6, stalls);
    drain("bp");
    compare_queues("bp");

    // Random packets, garbage between them, random backpressure.
    rand_bp = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 40);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) send(IN_W'($urandom), 1'b0, 1'($urandom_range(0, 1)), stalls);
      for (int i = 0; i < len; i++)
        send(IN_W'($urandom), (i == 0) || ($urandom_range(0, 15) == 0), i == len - 1, stalls);
    end
    rand_bp = 1'b0;
    drain("random");
    compare_queues("random");
    check(err_seen, err_exp, "random_err_count");

    // Reset in the middle of a packet.
    for (int i = 0; i < 10; i++) send(IN_W'($urandom), i == 0, 1'b0, stalls);
    rst = 1'b1;
    m_in_pkt = 1'b0;
    m_bits.delete();
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    #1;
    check({valid_out, data_out, sop_out, eop_out, err_out}, 36'h0, "rst_mid_outputs");
    check(ready_out, 1'b1, "rst_mid_ready");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) send(IN_W'(i), i == 0, i == 31, stalls);
    drain("rerun");
    check(got_q.size(), aligned_ref.size(), "rerun_count");
    for (int k = 0; k < aligned_ref.size() && k < got_q.size(); k++)
      check(got_q[k], aligned_ref[k], "rerun_word");
    compare_queues("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
